// File: rtl/frame_dump_stream.sv
// Captures one video frame on request and streams it out as a top-down BMP file
// (54-byte header, pixel rows padded to 4 bytes) over a valid/ready byte interface.
module frame_dump_stream #(
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int BPP        = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        pix_en,
    input  logic        vsync_n,
    input  logic        blank,
    input  logic [23:0] rgb,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam int ROWB     = H_VISIBLE * BPP / 8;
    localparam int PAD      = (4 - ROWB % 4) % 4;
    localparam int FILESIZE = 54 + (ROWB + PAD) * V_VISIBLE;
    localparam int NBYTES   = BPP / 8;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(H_VISIBLE + 1);
    localparam int RW       = $clog2(V_VISIBLE + 1);

    localparam logic [31:0] FSZ_W = 32'(FILESIZE);
    localparam logic [31:0] NEGV_W = 32'(-V_VISIBLE);
    localparam logic [31:0] HV_W = 32'(H_VISIBLE);
    localparam logic [31:0] PLANE_BPP_W = {16'(BPP), 16'd1};

    typedef enum logic [1:0] {CapIdle, CapArmed, CapRun} cap_st_e;
    typedef enum logic [2:0] {OutIdle, OutHdr, OutData, OutPad, OutDone} out_st_e;

    cap_st_e        cap_q, cap_d;
    out_st_e        out_q, out_d;
    logic           vs_prev_q;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [RW-1:0]  orow_q, orow_d;
    logic [5:0]     hidx_q, hidx_d;
    logic [1:0]     bidx_q, bidx_d;
    logic [1:0]     pidx_q, pidx_d;

    logic [24:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;
    logic [24:0]    head;
    logic [15:0]    w16;
    logic           full, empty, push, pop, drop;
    logic           arm_ok, cap_start, vis, last_col, last_pix, last_row, row_end, xfer;
    logic [7:0]     pix_byte;

    // Header bytes 2..53 are 32-bit little-endian words aligned at offset 2.
    function automatic logic [7:0] hdr_byte(input logic [5:0] i);
        logic [5:0]  o;
        logic [31:0] w;
        o = i - 6'd2;
        unique case (o[5:2])
            4'd0:    w = FSZ_W;
            4'd2:    w = 32'd54;
            4'd3:    w = 32'd40;
            4'd4:    w = HV_W;
            4'd5:    w = NEGV_W;
            4'd6:    w = PLANE_BPP_W;
            default: w = 32'd0;
        endcase
        w = w >> {o[1:0], 3'b000};
        if (i == 6'd0) return 8'h42;
        if (i == 6'd1) return 8'h4D;
        return w[7:0];
    endfunction

    assign arm_ok    = arm && !busy;
    assign cap_start = (cap_q == CapArmed) && pix_en && !vsync_n && vs_prev_q;
    assign vis       = (cap_q == CapRun) && pix_en && !blank;
    assign last_col  = col_q == CW'(H_VISIBLE - 1);
    assign last_pix  = last_col && (row_q == RW'(V_VISIBLE - 1));
    assign last_row  = orow_q == RW'(V_VISIBLE - 1);

    assign full  = cnt_q == (AW + 1)'(FIFO_DEPTH);
    assign empty = cnt_q == '0;
    assign push  = vis && (!full || pop);
    assign drop  = vis && full && !pop;
    assign head  = mem[rd_q];
    assign w16   = {1'b0, head[23:19], head[15:11], head[7:3]};
    assign xfer  = byte_valid && byte_ready;

    // Byte of the FIFO head selected by the serialiser position.
    always_comb begin
        pix_byte = 8'h00;
        if (BPP == 16) begin
            pix_byte = bidx_q[0] ? w16[15:8] : w16[7:0];
        end else begin
            case (bidx_q)
                2'd0:    pix_byte = head[7:0];
                2'd1:    pix_byte = head[15:8];
                default: pix_byte = head[23:16];
            endcase
        end
    end

    // Capture FSM next state and pixel position counters.
    always_comb begin
        cap_d = cap_q;
        col_d = col_q;
        row_d = row_q;
        case (cap_q)
            CapIdle:  if (arm_ok) cap_d = CapArmed;
            CapArmed: if (cap_start) begin
                cap_d = CapRun;
                col_d = '0;
                row_d = '0;
            end
            CapRun: if (vis) begin
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (last_pix) begin
                    cap_d = CapIdle;
                    row_d = '0;
                end
            end
            default: cap_d = CapIdle;
        endcase
    end

    // Output FSM: byte source selection and stream sequencing.
    always_comb begin
        out_d      = out_q;
        hidx_d     = hidx_q;
        bidx_d     = bidx_q;
        pidx_d     = pidx_q;
        orow_d     = orow_q;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pop        = 1'b0;
        row_end    = 1'b0;
        case (out_q)
            OutIdle: if (cap_start) begin
                out_d  = OutHdr;
                hidx_d = '0;
            end
            OutHdr: begin
                byte_valid = 1'b1;
                byte_data  = hdr_byte(hidx_q);
                if (xfer) begin
                    if (hidx_q == 6'd53) begin
                        out_d  = OutData;
                        bidx_d = '0;
                        orow_d = '0;
                    end else begin
                        hidx_d = hidx_q + 6'd1;
                    end
                end
            end
            OutData: begin
                if (!empty) begin
                    byte_valid = 1'b1;
                    byte_data  = pix_byte;
                    if (xfer) begin
                        if (bidx_q == 2'(NBYTES - 1)) begin
                            bidx_d  = '0;
                            pop     = 1'b1;
                            row_end = head[24];
                        end else begin
                            bidx_d = bidx_q + 2'd1;
                        end
                    end
                end else if (cap_q == CapIdle) begin
                    // Capture finished but rows are still owed (their pixels were dropped).
                    row_end = 1'b1;
                end
            end
            OutPad: begin
                byte_valid = 1'b1;
                if (xfer) begin
                    if (pidx_q == 2'(PAD - 1)) begin
                        if (last_row) begin
                            out_d = OutDone;
                        end else begin
                            orow_d = orow_q + 1'b1;
                            out_d  = OutData;
                        end
                    end else begin
                        pidx_d = pidx_q + 2'd1;
                    end
                end
            end
            OutDone: begin
                out_d  = OutIdle;
                orow_d = '0;
            end
            default: out_d = OutIdle;
        endcase
        if (row_end) begin
            if (PAD > 0) begin
                out_d  = OutPad;
                pidx_d = '0;
            end else if (last_row) begin
                out_d = OutDone;
            end else begin
                orow_d = orow_q + 1'b1;
            end
        end
    end

    // State registers, FIFO pointers and vsync history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= CapIdle;
            out_q     <= OutIdle;
            vs_prev_q <= 1'b1;
            col_q     <= '0;
            row_q     <= '0;
            orow_q    <= '0;
            hidx_q    <= '0;
            bidx_q    <= '0;
            pidx_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            cap_q  <= cap_d;
            out_q  <= out_d;
            col_q  <= col_d;
            row_q  <= row_d;
            orow_q <= orow_d;
            hidx_q <= hidx_d;
            bidx_q <= bidx_d;
            pidx_q <= pidx_d;
            if (pix_en) vs_prev_q <= vsync_n;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop) cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // FIFO storage; bit 24 marks the last stored pixel of a row. A dropped
    // end-of-row pixel moves that mark onto the newest stored entry.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {last_col, rgb};
        else if (drop && last_col) mem[wr_q - 1'b1][24] <= 1'b1;
    end

    // Sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (arm_ok) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (out_q == OutDone) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_dump_stream.sv
// Bench for frame_dump_stream: three small instances (24 bpp, 16 bpp, 4-deep FIFO)
// share the video inputs; byte streams are compared against a file-level BMP model.
module tb_frame_dump_stream;
    localparam int H = 3;
    localparam int V = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, arm, pix_en, vsync_n, blank, clr;
    logic [23:0] rgb;
    logic rdy_a, rdy_b, rdy_c, rnd_a, rnd_b, rnd_ready;
    logic ra, rb, rc;
    logic [7:0] da, db, dc;
    logic va, vb, vc, busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;

    assign ra = rnd_ready ? rnd_a : rdy_a;
    assign rb = rnd_ready ? rnd_b : rdy_b;
    assign rc = rdy_c;

    frame_dump_stream #(.H_VISIBLE(H), .V_VISIBLE(V), .BPP(24), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .arm(arm), .pix_en(pix_en), .vsync_n(vsync_n), .blank(blank),
        .rgb(rgb), .byte_data(da), .byte_valid(va), .byte_ready(ra), .busy(busy_a),
        .done(done_a), .overflow(ovf_a));
    frame_dump_stream #(.H_VISIBLE(H), .V_VISIBLE(V), .BPP(16), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(arm), .pix_en(pix_en), .vsync_n(vsync_n), .blank(blank),
        .rgb(rgb), .byte_data(db), .byte_valid(vb), .byte_ready(rb), .busy(busy_b),
        .done(done_b), .overflow(ovf_b));
    frame_dump_stream #(.H_VISIBLE(H), .V_VISIBLE(V), .BPP(24), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .arm(arm), .pix_en(pix_en), .vsync_n(vsync_n), .blank(blank),
        .rgb(rgb), .byte_data(dc), .byte_valid(vc), .byte_ready(rc), .busy(busy_c),
        .done(done_c), .overflow(ovf_c));

    logic [7:0]  qa[$], qb[$], qc[$], sa[$], sb[$], exp_q[$];
    logic [23:0] pix_q[$];
    int checks = 0;
    int failures = 0;

    // Transferred-byte monitors.
    always @(posedge clk) begin
        if (clr) begin
            qa.delete(); qb.delete(); qc.delete();
        end else begin
            if (va && ra) qa.push_back(da);
            if (vb && rb) qb.push_back(db);
            if (vc && rc) qc.push_back(dc);
        end
    end

    initial begin
        rnd_a = 1'b1;
        rnd_b = 1'b1;
        forever begin
            @(negedge clk);
            rnd_a = 1'($urandom_range(0, 1));
            rnd_b = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic put_le(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 32'hFF));
    endtask

    // Reference BMP file for the pixels in pix_q at the given depth.
    task automatic build_exp(input int bpp);
        int rowb, pad, fsz;
        logic [23:0] p;
        logic [15:0] w;
        rowb = H * bpp / 8;
        pad  = (4 - rowb % 4) % 4;
        fsz  = 54 + (rowb + pad) * V;
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        put_le(32'(fsz), 4); put_le(0, 4); put_le(54, 4); put_le(40, 4);
        put_le(32'(H), 4); put_le(32'(-V), 4); put_le(1, 2); put_le(32'(bpp), 2);
        put_le(0, 4); put_le(0, 4); put_le(0, 4); put_le(0, 4); put_le(0, 4); put_le(0, 4);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                p = pix_q[r * H + c];
                if (bpp == 24) begin
                    exp_q.push_back(p[7:0]); exp_q.push_back(p[15:8]); exp_q.push_back(p[23:16]);
                end else begin
                    w = {1'b0, p[23:19], p[15:11], p[7:3]};
                    exp_q.push_back(w[7:0]); exp_q.push_back(w[15:8]);
                end
            end
            for (int k = 0; k < pad; k++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic cmp_stream(input string nm, input int sel, input int upto);
        logic [7:0] g[$];
        int nbad, n;
        case (sel)
            0: g = qa;
            1: g = qb;
            default: g = qc;
        endcase
        n = (upto > 0) ? upto : exp_q.size();
        if (upto == 0) chk({nm, " length"}, g.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < n; i++)
            if (i >= g.size() || i >= exp_q.size() || g[i] !== exp_q[i]) nbad++;
        chk({nm, " bytes differing"}, nbad, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; arm = 1'b0; pix_en = 1'b0; vsync_n = 1'b1; blank = 1'b1; rgb = '0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr = 1'b0;
    endtask

    task automatic clear_q();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic vsync_fall();
        repeat (2) begin
            @(negedge clk);
            pix_en = 1'b1; vsync_n = 1'b1; blank = 1'b1;
        end
        @(negedge clk) vsync_n = 1'b0;
        @(negedge clk);
        vsync_n = 1'b1; pix_en = 1'b0;
    endtask

    task automatic drive_frame(input bit rnd);
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        vsync_fall();
        for (int i = 0; i < H * V; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    pix_en = 1'($urandom_range(0, 1)); blank = 1'b1; rgb = 24'($urandom);
                end
            end
            @(negedge clk);
            pix_en = 1'b1; blank = 1'b0; rgb = pix_q[i];
        end
        @(negedge clk);
        pix_en = 1'b0; blank = 1'b1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!(done_a && done_b && done_c) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " completes"}, {done_a, done_b, done_c}, 3'b111);
    endtask

    task automatic wait_qa(input int cnt);
        int n = 0;
        while (qa.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("byte count reached", (qa.size() >= cnt), 1);
    endtask

    // Holds dut_a's sink off for 10 cycles while the header byte at index 10 is offered.
    task automatic stall_a();
        wait_qa(10);
        rdy_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("stall valid", va, 1);
            chk("stall data", da, exp_q[10]);
            @(negedge clk);
        end
        chk("stall no transfer", qa.size(), 10);
        rdy_a = 1'b1;
    endtask

    typedef struct {
        int         sel;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic [7:0] got;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1; rnd_ready = 1'b0;
        vecs = '{'{0, 0, 8'h42}, '{0, 1, 8'h4D}, '{0, 2, 8'h4E}, '{0, 3, 8'h00}, '{0, 5, 8'h00},
                 '{0, 10, 8'h36}, '{0, 14, 8'h28}, '{0, 18, 8'h03}, '{0, 22, 8'hFE},
                 '{0, 25, 8'hFF}, '{0, 28, 8'h18}, '{0, 54, 8'h33}, '{0, 55, 8'h22},
                 '{0, 56, 8'h11}, '{0, 63, 8'h00}, '{0, 65, 8'h00}, '{0, 66, 8'h33},
                 '{1, 2, 8'h46}, '{1, 28, 8'h10}, '{1, 54, 8'h00}, '{1, 55, 8'h7C},
                 '{1, 60, 8'h00}, '{1, 61, 8'h00}, '{1, 62, 8'h00}, '{1, 63, 8'h7C}};

        do_reset();
        chk("reset valid", va, 0);
        chk("reset data", da, 8'h00);
        chk("reset busy", busy_a, 0);
        chk("reset done", done_a, 0);
        chk("reset overflow", ovf_a, 0);

        // 24 bpp frame; the 4-deep instance is stalled so two pixels drop.
        pix_q.delete();
        repeat (H * V) pix_q.push_back(24'h112233);
        rdy_c = 1'b0;
        drive_frame(0);
        rdy_c = 1'b1;
        wait_done("frame1");
        build_exp(24);
        cmp_stream("frame1 a", 0, 0);
        chk("frame1 done", done_a, 1);
        chk("frame1 busy", busy_a, 0);
        chk("frame1 overflow a", ovf_a, 0);
        chk("overflow c len", qc.size(), 78 - 6);
        chk("overflow c flag", ovf_c, 1);
        sa = qa;

        // 16 bpp pixel format plus a sink stall on the 24 bpp stream.
        clear_q();
        pix_q.delete();
        repeat (H * V) pix_q.push_back(24'hF80000);
        build_exp(24);
        fork
            drive_frame(0);
            stall_a();
        join
        wait_done("frame2");
        cmp_stream("frame2 a stalled", 0, 0);
        build_exp(16);
        cmp_stream("frame2 b", 1, 0);
        sb = qb;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].sel == 0) got = (vecs[i].idx < sa.size()) ? sa[vecs[i].idx] : 8'hxx;
            else got = (vecs[i].idx < sb.size()) ? sb[vecs[i].idx] : 8'hxx;
            chk($sformatf("vec %0d byte %0d", i, vecs[i].idx), got, vecs[i].exp);
        end

        // Random pixels, blanking gaps and sink back-pressure.
        for (int f = 0; f < 3; f++) begin
            clear_q();
            pix_q.delete();
            repeat (H * V) pix_q.push_back(24'($urandom));
            rnd_ready = 1'b1;
            drive_frame(1);
            wait_done("random");
            rnd_ready = 1'b0;
            build_exp(24);
            cmp_stream("random a", 0, 0);
            build_exp(16);
            cmp_stream("random b", 1, 0);
            chk("random overflow", {ovf_a, ovf_b}, 2'b00);
        end

        // Re-arm while busy, then reset mid-data.
        clear_q();
        pix_q.delete();
        repeat (H * V) pix_q.push_back(24'h112233);
        build_exp(24);
        drive_frame(0);
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        chk("rearm busy", busy_a, 1);
        wait_qa(60);
        cmp_stream("rearm prefix", 0, 60);
        chk("rearm done", done_a, 0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midreset valid", va, 0);
        chk("midreset busy", busy_a, 0);
        chk("midreset data", da, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        vsync_fall();
        repeat (4) @(negedge clk);
        chk("no capture without arm", {busy_a, va}, 2'b00);
        chk("no bytes without arm", qa.size(), 0);
        drive_frame(0);
        wait_done("after reset");
        cmp_stream("after reset a", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
